// File: rtl/pipe_buf_pkg.sv
// pipe_buf_pkg
// Shared constants for the elastic pipeline-stage buffer.
//   EXE_CTRL_W / EXE_DATA_W : default EXE->MEM bundle widths
//   *_LSB / *_W             : payload field placement (ALU result at the MSB end)
//   *_IDX                   : control bit positions (MEM_W_EN is the LSB)
//   ptr_w()                 : pointer storage width for a given depth
package pipe_buf_pkg;

  localparam int EXE_CTRL_W = 3;
  localparam int EXE_DATA_W = 72;

  // Payload layout: {alu_res[31:0], val_rm[31:0], dest[3:0], st_val[3:0]}
  localparam int ALU_RES_W   = 32;
  localparam int VAL_RM_W    = 32;
  localparam int DEST_W      = 4;
  localparam int ST_VAL_W    = 4;
  localparam int ST_VAL_LSB  = 0;
  localparam int DEST_LSB    = ST_VAL_LSB + ST_VAL_W;
  localparam int VAL_RM_LSB  = DEST_LSB + DEST_W;
  localparam int ALU_RES_LSB = VAL_RM_LSB + VAL_RM_W;

  // Control layout: {wb_en, mem_r_en, mem_w_en}
  localparam int MEM_W_EN_IDX = 0;
  localparam int MEM_R_EN_IDX = 1;
  localparam int WB_EN_IDX    = 2;

  // A single-entry buffer needs no pointer bits; one constant bit keeps
  // the port legal and is optimised away.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ptr.sv
// pipe_buf_ptr
// Wrapping circular-buffer pointer, modulo DEPTH (power of two).
//   clk, rst : clock, synchronous active-high reset (ptr -> 0)
//   clr      : return to 0 next cycle (flush)
//   inc      : advance by one, wrapping
//   ptr      : current pointer; constant 0 when DEPTH == 1
module pipe_buf_ptr
  import pipe_buf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [ptr_w(DEPTH)-1:0] ptr
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      // Power-of-two depth: natural binary overflow is the wrap.
      ptr_d = (DEPTH == 1) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
// Elastic pipeline-stage buffer holding up to DEPTH {ctrl, data} bundles
// with valid/ready on both sides plus flush and freeze.
//   clk, rst             : clock, synchronous active-high reset
//   flush                : drop all entries (beats freeze and traffic)
//   freeze               : hold all state, no push/pop
//   in_valid/in_ready    : upstream handshake (in_ready ignores out_ready)
//   in_ctrl/in_data      : upstream bundle
//   out_valid/out_ready  : downstream handshake
//   out_ctrl/out_data    : head bundle; out_ctrl is 0 while empty
//   count                : occupancy
// Build option PIPE_BUF_ZERO_DATA_EN: out_data forced to 0 while empty and
// storage cleared on rst/flush. Without it storage has no reset and
// out_data is don't-care while empty.
module pipe_stage_buf
  import pipe_buf_pkg::*;
#(
  parameter int CTRL_W = EXE_CTRL_W,
  parameter int DATA_W = EXE_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       freeze,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = CTRL_W + DATA_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [EW-1:0]    head;
  logic [DEPTH-1:0] wr_en;
  logic             push;
  logic             pop;

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q != FULL) && !freeze && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !freeze && !flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_wp (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wp)
  );

  pipe_buf_ptr #(.DEPTH(DEPTH)) u_rp (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rp)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign wr_en[gi] = push && (wp == PW'(gi));
`ifdef PIPE_BUF_ZERO_DATA_EN
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        mem_q[gi] <= '0;
      end else if (wr_en[gi]) begin
        mem_q[gi] <= {in_ctrl, in_data};
      end
    end
`else
    always_ff @(posedge clk) begin
      if (wr_en[gi]) begin
        mem_q[gi] <= {in_ctrl, in_data};
      end
    end
`endif
  end

  if (DEPTH == 1) begin : g_head_single
    assign head = mem_q[0];
  end else begin : g_head_mux
    assign head = mem_q[rp];
  end

  assign out_ctrl = out_valid ? head[EW-1:DATA_W] : '0;
`ifdef PIPE_BUF_ZERO_DATA_EN
  assign out_data = out_valid ? head[DATA_W-1:0] : '0;
`else
  assign out_data = head[DATA_W-1:0];
`endif
  assign count = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
  localparam int CTRL_W = 3;
  localparam int DATA_W = 72;
  localparam int DEPTH  = 2;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, flush, freeze, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CW-1:0]     count;

  int total = 0;
  int bad   = 0;
  logic [CTRL_W+DATA_W-1:0] sb_q [$];
  int cyc = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .count(count)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL cyc=%0d %s: got %h want %h", cyc, tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // Check the current outputs against the reference queue, then advance the
  // model by what the coming edge should do.
  task automatic step();
    logic m_ready, m_push, m_pop;
    logic [CTRL_W+DATA_W-1:0] head;
    @(negedge clk);
    m_ready = (sb_q.size() != DEPTH) && !freeze && !flush;
    check("count", 80'(count), 80'(sb_q.size()));
    check("out_valid", 80'(out_valid), 80'(sb_q.size() != 0));
    check("in_ready", 80'(in_ready), 80'(m_ready));
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      check("out_ctrl", 80'(out_ctrl), 80'(head[CTRL_W+DATA_W-1:DATA_W]));
      check("out_data", 80'(out_data), 80'(head[DATA_W-1:0]));
    end else begin
      check("out_ctrl_empty", 80'(out_ctrl), 80'(0));
`ifdef PIPE_BUF_ZERO_DATA_EN
      check("out_data_empty", 80'(out_data), 80'(0));
`endif
    end
    m_push = in_valid && m_ready;
    m_pop  = (sb_q.size() != 0) && out_ready && !freeze && !flush;
    $display("cyc=%0d rst=%0b fl=%0b fz=%0b push=%0b pop=%0b cnt=%0d", cyc, rst, flush,
             freeze, m_push, m_pop, count);
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (m_pop) void'(sb_q.pop_front());
      if (m_push) sb_q.push_back({in_ctrl, in_data});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    @(posedge clk);
    #1;
    step();                       // second reset cycle
    rst = 1'b0;
    step();                       // idle after reset

    // Single pass
    out_ready = 1'b1;
    drive(1'b1, 3'b101, 72'h1_2345_6789_ABCD_EF01);
    step();
    drive(1'b0, '0, '0);
    step();
    step();

    // Fill with back-pressure, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 3'b100, 72'hAA_AAAA_AAAA_AAAA_AAAA); step();
    drive(1'b1, 3'b010, 72'hBB_BBBB_BBBB_BBBB_BBBB); step();
    drive(1'b1, 3'b111, 72'hCC_CCCC_CCCC_CCCC_CCCC); step();
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step(); step(); step();

    // Simultaneous push/pop at count 1 over 8 bundles
    out_ready = 1'b0;
    drive(1'b1, 3'b001, rnd_data()); step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), rnd_data());
      step();
    end
    drive(1'b0, '0, '0);
    step(); step();

    // Freeze with a full buffer and active traffic
    out_ready = 1'b0;
    drive(1'b1, 3'b110, rnd_data()); step();
    drive(1'b1, 3'b011, rnd_data()); step();
    freeze = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b111, rnd_data());
      step();
    end
    freeze = 1'b0;
    drive(1'b0, '0, '0);
    step();                       // first entry pops, confirming order kept

    // Flush at count 2 with a concurrent push
    out_ready = 1'b0;
    drive(1'b1, 3'b101, rnd_data()); step();
    drive(1'b1, 3'b100, rnd_data()); step();
    flush = 1'b1;
    drive(1'b1, 3'b111, 72'hDE_ADDE_ADDE_ADDE_ADDE);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step(); step();

    // Random mix, including a reset mid-transfer
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom), 3'($urandom), rnd_data());
      out_ready = 1'($urandom);
      freeze    = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      rst       = (i == 30);
      step();
    end
    rst = 1'b0; flush = 1'b0; freeze = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
